nibble_change_logger: RTL and testbench

Downstream consumer of the 4-bit clock-muxed value stream, such as the `out_val` bus produced by the clk/rstn select stage. On each enabled clock it samples the bus and detects value changes. Each change is pushed, with a free-running timestamp, into a small FIFO that firmware or the bench drains through a valid/ready interface. This turns a glitchy-looking waveform into an ordered event log.

---
 rtl/nibble_change_logger_if.sv | 16 +
 rtl/nibble_change_logger.sv | 87 ++++++++
 tb/tb_nibble_change_logger.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_change_logger_if.sv
// Event-log read port of nibble_change_logger: one {data, timestamp} entry per transfer.
interface nibble_change_logger_if #(
    parameter int DATA_W = 4,
    parameter int TS_W   = 8
);
    // Valid/ready: the master raises out_valid while an entry is available and holds
    // out_data/out_ts stable until the cycle the slave has out_ready high; the entry
    // transfers on that rising edge. out_ready is ignored while out_valid is low.
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TS_W-1:0]   out_ts;

    modport master (output out_valid, output out_data, output out_ts, input out_ready);
    modport slave  (input out_valid, input out_data, input out_ts, output out_ready);
endinterface

// File: rtl/nibble_change_logger.sv
// Samples a small value bus, logs each change with a free-running timestamp into a
// FIFO drained over a valid/ready port; a sticky flag records dropped events.
module nibble_change_logger #(
    parameter int DATA_W = 4,
    parameter int TS_W   = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     en,
    input  logic [DATA_W-1:0]        din,
    input  logic                     clr_ovf,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    nibble_change_logger_if.master   log_if
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [TS_W-1:0]   mem_ts   [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [TS_W-1:0]   ts_cnt;
    logic [DATA_W-1:0] prev;
    logic              first;

    logic sample_event;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign full         = (count == FULL_CNT);
    assign sample_event = en && (first || (din != prev));
    assign pop          = log_if.out_valid && log_if.out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push         = sample_event && (!full || pop);
    assign drop         = sample_event && full && !pop;

    assign log_if.out_valid = (count != '0);
    assign log_if.out_data  = log_if.out_valid ? mem_data[rd_ptr] : '0;
    assign log_if.out_ts    = log_if.out_valid ? mem_ts[rd_ptr]   : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ts_cnt   <= '0;
            prev     <= '0;
            first    <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (en) begin
                ts_cnt <= ts_cnt + TS_W'(1);
                prev   <= din;
                first  <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= din;
            mem_ts[wr_ptr]   <= ts_cnt;
        end
    end
endmodule

// File: tb/tb_nibble_change_logger.sv
// Scoreboard bench for nibble_change_logger: a queue-based reference model feeds
// expected entries; a negedge monitor pops and compares on every handshake.
module tb_nibble_change_logger;
    localparam int DATA_W = 4;
    localparam int TS_W   = 8;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rstn;
    logic              en;
    logic [DATA_W-1:0] din;
    logic              clr_ovf;
    logic [3:0]        count;
    logic              overflow;

    nibble_change_logger_if #(.DATA_W(DATA_W), .TS_W(TS_W)) lg ();

    nibble_change_logger #(.DATA_W(DATA_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .din      (din),
        .clr_ovf  (clr_ovf),
        .count    (count),
        .overflow (overflow),
        .log_if   (lg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: plain queue of {data, ts} plus occupancy/flags.
    logic [DATA_W+TS_W-1:0] exp_q[$];
    int                m_cnt;
    bit                m_ovf;
    int                m_ts;
    logic [DATA_W-1:0] m_prev;
    bit                m_first;
    bit                m_ev;
    bit                m_pop;
    bit                m_push;

    bit                held_v;
    logic [DATA_W-1:0] held_d;
    logic [TS_W-1:0]   held_t;
    logic [DATA_W-1:0] last_data;
    logic [TS_W-1:0]   last_ts;
    int                n_popped;
    int                max_cnt;
    logic [DATA_W+TS_W-1:0] e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cnt   = 0;
        m_ovf   = 0;
        m_ts    = 0;
        m_prev  = '0;
        m_first = 1;
        held_v  = 0;
    endtask

    always @(posedge clk) begin
        if (rstn) begin
            m_ev = 0;
            if (en) begin
                m_ev    = m_first || (din != m_prev);
                m_prev  = din;
                m_first = 0;
            end
            m_pop  = (m_cnt > 0) && lg.out_ready;
            m_push = m_ev && ((m_cnt < DEPTH) || m_pop);
            if (m_push) exp_q.push_back({din, TS_W'(m_ts)});
            if (m_ev && !m_push) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
            m_cnt = m_cnt + int'(m_push) - int'(m_pop);
            if (en) m_ts = (m_ts + 1) % (1 << TS_W);
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            check("out_valid", lg.out_valid, m_cnt != 0);
            check("count", count, m_cnt);
            check("overflow", overflow, m_ovf);
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (held_v) begin
                check("hold_data", lg.out_data, held_d);
                check("hold_ts", lg.out_ts, held_t);
            end
            if (lg.out_valid && lg.out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL pop_empty: got data=%0h ts=%0h expected no entry", lg.out_data, lg.out_ts);
                end else begin
                    total--;
                    e = exp_q.pop_front();
                    check("pop_data", lg.out_data, e[DATA_W+TS_W-1:TS_W]);
                    check("pop_ts", lg.out_ts, e[TS_W-1:0]);
                end
                last_data = lg.out_data;
                last_ts   = lg.out_ts;
                n_popped++;
            end
            held_v = lg.out_valid && !lg.out_ready;
            held_d = lg.out_data;
            held_t = lg.out_ts;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset lands mid-cycle so the asynchronous clear is observed before any edge.
    task automatic do_reset();
        step();
        #2;
        rstn = 0;
        model_reset();
        #1;
        check("rst_valid", lg.out_valid, 0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_data", lg.out_data, 0);
        check("rst_ts", lg.out_ts, 0);
        en = 0; clr_ovf = 0; lg.out_ready = 0;
        step();
        step();
        rstn = 1;
    endtask

    task automatic drain();
        int n;
        en = 0;
        clr_ovf = 0;
        lg.out_ready = 1;
        n = 0;
        while ((m_cnt != 0 || lg.out_valid) && n < 40) begin
            step();
            n++;
        end
        total++;
        if (n >= 40) begin
            bad++;
            $display("FAIL drain_timeout: got count=%0d expected 0", count);
        end
        lg.out_ready = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish by 1ms");
        $fatal(1);
    end

    initial begin
        rstn = 0; en = 0; din = 0; clr_ovf = 0; lg.out_ready = 0;
        model_reset();
        n_popped = 0;
        max_cnt = 0;
        do_reset();

        // 1: constant value logs once
        n_popped = 0;
        en = 1; din = 4'h5; lg.out_ready = 1;
        for (int i = 0; i < 10; i++) step();
        check("t1_pops", n_popped, 1);
        check("t1_data", last_data, 4'h5);
        check("t1_ts", last_ts, 0);
        drain();

        // 2: each cycle a new value, consumer always ready
        do_reset();
        max_cnt = 0;
        n_popped = 0;
        en = 1; lg.out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            din = DATA_W'(i);
            step();
        end
        drain();
        check("t2_pops", n_popped, 4);
        check("t2_max_count", max_cnt <= 1, 1);
        check("t2_last_ts", last_ts, 3);

        // 3: fill past capacity with no consumer
        do_reset();
        en = 1; lg.out_ready = 0;
        for (int i = 0; i < 10; i++) begin
            din = DATA_W'(i);
            step();
        end
        en = 0;
        step();
        check("t3_count", count, 8);
        check("t3_overflow", overflow, 1);

        // 4: full FIFO, simultaneous push and pop
        en = 1; din = 4'hA; lg.out_ready = 1;
        step();
        en = 0; lg.out_ready = 0;
        step();
        check("t4_count", count, 8);
        check("t4_overflow", overflow, 1);
        clr_ovf = 1;
        step();
        clr_ovf = 0;
        check("t4_clr", overflow, 0);
        drain();
        check("t4_last_data", last_data, 4'hA);

        // 5: backpressure toggling
        do_reset();
        en = 1;
        for (int i = 1; i <= 3; i++) begin
            din = DATA_W'(i);
            step();
        end
        en = 0;
        n_popped = 0;
        for (int i = 0; i < 12; i++) begin
            lg.out_ready = i[0];
            step();
        end
        drain();
        check("t5_pops", n_popped, 3);
        check("t5_last_data", last_data, 3);

        // 6: timestamp wrap, then reset with entries queued
        do_reset();
        en = 1; din = 4'h3; lg.out_ready = 1;
        for (int i = 0; i < 256; i++) step();
        din = 4'h4;
        step();
        drain();
        check("t6_wrap_data", last_data, 4'h4);
        check("t6_wrap_ts", last_ts, 0);
        en = 1; lg.out_ready = 0;
        din = 4'h1; step();
        din = 4'h2; step();
        en = 0; step();
        check("t6_count2", count, 2);
        do_reset();
        en = 1; din = 4'h7; lg.out_ready = 1;
        step();
        step();
        check("t6_post_rst_data", last_data, 4'h7);
        check("t6_post_rst_ts", last_ts, 0);
        drain();

        // Random traffic with occasional starvation of the consumer
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            en = ($urandom_range(0, 9) != 0);
            din = ($urandom_range(0, 3) == 0) ? DATA_W'($urandom) : DATA_W'($urandom_range(0, 2));
            if ((i / 200) % 2 == 0) lg.out_ready = ($urandom_range(0, 2) != 0);
            else lg.out_ready = ($urandom_range(0, 5) == 0);
            clr_ovf = ($urandom_range(0, 15) == 0);
            step();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
